// File: rtl/apb_master_bridge.sv
// APB initiator: turns single core load/store requests into one APB transfer each,
// with SETUP/ACCESS phasing, wait-state handling and a bus-hang timeout.
module apb_master_bridge #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        from_top_clk,
  input  logic                        preset_n,
  // core request port
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDRESS_LENGTH-1:0]   req_addr,
  input  logic [DATA_LENGTH-1:0]      req_wdata,
  input  logic [DATA_LENGTH/8-1:0]    req_strb,
  // core response port
  output logic                        rsp_valid,
  output logic [DATA_LENGTH-1:0]      rsp_rdata,
  output logic                        rsp_error,
  // APB completer side
  output logic [ADDRESS_LENGTH-1:0]   paddr,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [DATA_LENGTH-1:0]      pwdata,
  output logic [DATA_LENGTH/8-1:0]    pstrb,
  input  logic                        pready,
  input  logic [DATA_LENGTH-1:0]      prdata,
  input  logic                        pslverr
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_inc;
  logic        w_timeout;

  assign w_wait_inc = r_wait_cnt + 16'd1;
  // Abort on the edge that records the TIMEOUT_CYCLES-th pready-low cycle.
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_wait_inc == TIMEOUT_LIM);

  // NOTE: every output is a flop written only here with <=, so all of them
  // update together on the edge and the async reset clears psel/penable at once.
  always_ff @(posedge from_top_clk or negedge preset_n) begin
    if (!preset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
      paddr      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      pstrb      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            paddr     <= req_addr;
            pwrite    <= req_write;
            // Reads drive no strobes and leave pwdata at its last write value.
            if (req_write) begin
              pwdata <= req_wdata;
              pstrb  <= req_strb;
            end else begin
              pstrb  <= '0;
            end
            psel      <= 1'b1;
            penable   <= 1'b0;
            req_ready <= 1'b0;
            r_state   <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          r_state <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_error <= pslverr;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            r_state   <= RESP;
          end else begin
            if (r_wait_cnt != 16'hFFFF) begin
              r_wait_cnt <= w_wait_inc;
            end
            if (w_timeout) begin
              rsp_rdata <= '0;
              rsp_error <= 1'b1;
              rsp_valid <= 1'b1;
              psel      <= 1'b0;
              penable   <= 1'b0;
              r_state   <= RESP;
            end
          end
        end

        RESP: begin
          rsp_valid  <= 1'b0;
          r_wait_cnt <= '0;
          req_ready  <= 1'b1;
          r_state    <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge; expected behaviour comes
// from a transaction-level model of latency, data and error rules.
module tb_apb_master_bridge;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_strb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the value pwdata must hold: last write data, zero after reset.
  logic [DW-1:0] m_pwdata = '0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .DATA_LENGTH   (DW),
    .ADDRESS_LENGTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .from_top_clk(clk),
    .preset_n    (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete request. nwait = pready-low ACCESS cycles the completer inserts;
  // late = cycles pready is left high after the response (must be ignored).
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input int nwait, input logic slverr,
                      input logic [DW-1:0] rdata, input int late);
    bit            aborted;
    int            rsp_edge;
    int            guard;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    logic [SW-1:0] exp_strb;

    aborted  = (TMO != 0) && (nwait >= TMO);
    rsp_edge = aborted ? 1 + TMO : 2 + nwait;
    exp_err  = aborted ? 1'b1 : slverr;
    exp_rd   = (aborted || wr) ? '0 : rdata;
    exp_strb = wr ? strb : '0;
    if (wr) m_pwdata = wdata;

    guard = 0;
    while (!req_ready && guard < 20) begin
      cycle();
      guard++;
    end
    check("req_ready_idle", req_ready, 1);

    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    pready    = 1'b0;
    cycle();
    // Scramble request fields so only the latched copy can satisfy the checks.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = SW'($urandom);
    req_write = ~wr;

    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_req_ready", req_ready, 0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, m_pwdata);
    check("setup_pstrb", pstrb, exp_strb);

    for (int c = 1; c <= rsp_edge; c++) begin
      if (!aborted && c == 2 + nwait) begin
        pready  = 1'b1;
        pslverr = slverr;
        prdata  = rdata;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
      cycle();
      if (c < rsp_edge) begin
        check("access_psel", psel, 1);
        check("access_penable", penable, 1);
        check("access_rsp_valid", rsp_valid, 0);
        check("access_paddr", paddr, addr);
        check("access_pwdata", pwdata, m_pwdata);
        check("access_pstrb", pstrb, exp_strb);
      end else begin
        check("resp_psel", psel, 0);
        check("resp_penable", penable, 0);
        check("resp_valid", rsp_valid, 1);
        check("resp_rdata", rsp_rdata, exp_rd);
        check("resp_error", rsp_error, exp_err);
        check("resp_req_ready", req_ready, 0);
      end
    end

    pready  = (late > 0);
    pslverr = 1'b1;
    prdata  = $urandom;
    cycle();
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
    check("post_psel", psel, 0);
    for (int k = 1; k < late; k++) begin
      cycle();
      check("late_rsp_valid", rsp_valid, 0);
      check("late_psel", psel, 0);
    end
    pready  = 1'b0;
    pslverr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    cycle();
    cycle();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_rsp_error", rsp_error, 0);
    rst_n = 1'b1;
    cycle();
    check("idle_psel", psel, 0);

    // Zero-wait write
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);
    // Read with three wait states
    xfer(1'b0, 32'h0000_0024, 32'h0, 4'h0, 3, 1'b0, 32'h1234_5678, 0);
    // Completer error, then a clean read
    xfer(1'b1, 32'h0000_0030, 32'hA5A5_0F0F, 4'h3, 0, 1'b1, 32'h0, 0);
    xfer(1'b0, 32'h0000_0034, 32'h0, 4'h0, 1, 1'b0, 32'hCAFE_F00D, 0);
    // Timeout on a read, late pready ignored
    xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, TMO, 1'b0, 32'hFFFF_FFFF, 3);
    // Longest successful wait just below the limit
    xfer(1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 4'h9, TMO - 1, 1'b0, 32'h0, 0);

    // Reset during ACCESS
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0050;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    check("pre_rst_penable", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_psel", psel, 0);
    check("async_rst_penable", penable, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    m_pwdata = '0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("in_rst_rsp_valid", rsp_valid, 0);
    end
    rst_n = 1'b1;
    cycle();
    check("after_rst_rsp_valid", rsp_valid, 0);
    xfer(1'b0, 32'h0000_0054, 32'h0, 4'h0, 1, 1'b0, 32'h7777_1234, 0);

    // Randomized transfers
    for (int i = 0; i < 16; i++) begin
      logic          wr;
      int            nw;
      wr = 1'($urandom);
      nw = $urandom_range(0, TMO + 1);
      xfer(wr, $urandom, $urandom, SW'($urandom), nw, 1'($urandom), $urandom,
           (nw >= TMO) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator. Accepts single load/store requests from the core-side request port and drives one APB transfer per request to the memory-mapped APB completer.
- Returns the read data and the completion status to the core.
- Provides the SETUP/ACCESS phasing, wait-state handling and a bus-hang timeout. The completer sits on the other end of the bus.

Parameters:
DATA_LENGTH, 32, width of pwdata/prdata/req_wdata/rsp_rdata
ADDRESS_LENGTH, 32, width of paddr/req_addr
TIMEOUT_CYCLES, 256, max ACCESS cycles with pready low before abort; 0 disables timeout (max 65535)

Ports:
from_top_clk  in  1  clock
preset_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core request present
req_ready  out  1  bridge can accept a request
req_write  in  1  1=write, 0=read
req_addr  in  ADDRESS_LENGTH  transfer address
req_wdata  in  DATA_LENGTH  write data
req_strb  in  DATA_LENGTH/8  write byte strobes
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_LENGTH  read data; valid with rsp_valid
rsp_error  out  1  pslverr or timeout; valid with rsp_valid
paddr  out  ADDRESS_LENGTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_LENGTH  APB write data
pstrb  out  DATA_LENGTH/8  APB byte strobes
pready  in  1  completer ready
prdata  in  DATA_LENGTH  completer read data
pslverr  in  1  completer error

Behaviour:
- All outputs are registered. Reset is asynchronous, active-low, one clock (from_top_clk).
- Reset values: psel, penable, pwrite, rsp_valid and rsp_error are 0. paddr, pwdata, pstrb and rsp_rdata are 0. req_ready is 1. The FSM is in IDLE and the wait counter is 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch req_write/addr/wdata/strb into paddr/pwrite/pwdata/pstrb and go to SETUP.
  - On a read, pstrb=0 and pwdata is held at its previous value.
- SETUP (exactly 1 cycle): psel=1, penable=0, req_ready=0. Next state is ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata/pstrb are held stable for the whole state.
  - Edge with pready=1: latch rsp_rdata=prdata (reads; writes latch 0) and rsp_error=pslverr. Drop psel and penable. Go to RESP.
  - Edge with pready=0: increment the wait counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, abort: drop psel and penable, rsp_error=1, rsp_rdata=0, go to RESP.
- RESP (1 cycle):
  - rsp_valid=1. There is no backpressure; the core must take the response.
  - Clear the wait counter.
  - Next state is IDLE, with req_ready=1 from the following cycle.
- Latency: request accepted at edge E0. psel is high from E0, penable from E1. With zero wait states, pready is sampled at E2 and rsp_valid is high E2–E3. With N wait states, add N cycles.
- Request throughput: one transfer per 4 cycles minimum.
- The bridge never issues back-to-back transfers without passing through IDLE.
- Requests presented while req_ready=0 are ignored. The core must hold req_valid until accepted.
- pslverr is sampled only on the pready=1 edge in ACCESS; pslverr at any other time is ignored.
- prdata is sampled only on completing read edges.
- Timeout abort: at most one completion per request. A late pready after the abort is ignored, because psel=0 then.
- Reset mid-transfer: psel/penable drop immediately (asynchronously) and no rsp_valid is produced for the aborted request.
- Wait-counter width: 16 bits.

Test Plan:
- Reset then idle → psel=penable=rsp_valid=0, req_ready=1, paddr=0.
- Write addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF, pready tied 1 → SETUP 1 cycle with psel=1/penable=0, then ACCESS 1 cycle with penable=1, then rsp_valid pulse with rsp_error=0; pwdata stable for both phases.
- Read addr=0x24, completer holds pready=0 for 3 cycles then returns prdata=0x1234_5678 → penable high 4 cycles, paddr constant, rsp_rdata=0x1234_5678, pstrb=0.
- Write with pready=1 and pslverr=1 → rsp_error=1; next read with pslverr=0 → rsp_error=0.
- TIMEOUT_CYCLES=4 and pready held 0 → after 4 wait cycles psel/penable drop, rsp_valid=1, rsp_error=1, rsp_rdata=0; pready raised afterwards is ignored.
- preset_n asserted during ACCESS → psel/penable go 0 without a clock edge, no rsp_valid; after release a new read completes normally.
